// File: rtl/tail_light_pkg.sv
// rtl/tail_light_pkg.sv - shared state encoding and lamp-count limits for the tail-light sequencer
package tail_light_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LEFT    = 3'd1,
      RIGHT   = 3'd2,
      HAZ_ON  = 3'd3,
      HAZ_OFF = 3'd4
   } state_t;

   localparam int LAMPS_MIN = 2;
   localparam int LAMPS_MAX = 8;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing a one-cycle step enable every TICK_DIV clocks
module tick_gen #(
   parameter int TICK_DIV = 12500000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   if (TICK_DIV < 2) begin : g_bad_div
      $error("tick_gen: TICK_DIV must be at least 2");
   end

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == CNT_LAST);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/tail_light_seq.sv
// rtl/tail_light_seq.sv - turn/hazard tail-light sequencer; TAIL_BRAKE_EN adds the steady brake overlay
module tail_light_seq
   import tail_light_pkg::*;
#(
   parameter int LAMPS      = 3,
   parameter int TICK_DIV   = 12500000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             left,
   input  logic             right,
   input  logic             halt,
`ifdef TAIL_BRAKE_EN
   input  logic             brake,
`endif
   output logic [LAMPS-1:0] led_l,
   output logic [LAMPS-1:0] led_r,
   output logic             busy,
   output logic             tick
);

   localparam int IW = $clog2(LAMPS + 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(LAMPS);

   if (LAMPS < LAMPS_MIN || LAMPS > LAMPS_MAX) begin : g_bad_lamps
      $error("tail_light_seq: LAMPS out of range");
   end

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [LAMPS-1:0] lamp_l_q, lamp_l_d, lamp_r_q, lamp_r_d;
   logic             busy_q, busy_d;
   logic [LAMPS-1:0] seq_pat, show_l, show_r;
   logic             haz;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk   (clk),
      .rst_n (rst),
      .tick  (tick)
   );

   always_comb begin
      haz     = halt | (left & right);
      state_d = state_q;
      idx_d   = idx_q;
      if (tick) begin
         case (state_q)
            IDLE: begin
               if (haz) begin
                  state_d = HAZ_ON;
               end else if (left) begin
                  state_d = LEFT;
                  idx_d   = IW'(1);
               end else if (right) begin
                  state_d = RIGHT;
                  idx_d   = IW'(1);
               end
            end
            LEFT, RIGHT: begin
               if (haz) begin
                  state_d = HAZ_ON;
                  idx_d   = '0;
               end else if (idx_q == IDX_LAST) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            HAZ_ON:  state_d = haz ? HAZ_OFF : IDLE;
            HAZ_OFF: state_d = haz ? HAZ_ON : IDLE;
            default: begin
               state_d = IDLE;
               idx_d   = '0;
            end
         endcase
      end

      // Inner lamps light first: the lowest idx_d lamps are on.
      for (int i = 0; i < LAMPS; i++) seq_pat[i] = (IW'(i) < idx_d);

      lamp_l_d = '0;
      lamp_r_d = '0;
      case (state_d)
         LEFT:    lamp_l_d = seq_pat;
         RIGHT:   lamp_r_d = seq_pat;
         HAZ_ON: begin
            lamp_l_d = '1;
            lamp_r_d = '1;
         end
         default: ;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         lamp_l_q <= '0;
         lamp_r_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         lamp_l_q <= lamp_l_d;
         lamp_r_q <= lamp_r_d;
         busy_q   <= busy_d;
      end
   end

`ifdef TAIL_BRAKE_EN
   logic brake_q, brake_d;
   logic brake_l, brake_r;

   // Brake lights any side not running a turn sequence; hazard states are left alone.
   always_comb begin
      brake_d = brake;
      brake_l = brake_q && (state_q == IDLE || state_q == RIGHT);
      brake_r = brake_q && (state_q == IDLE || state_q == LEFT);
      show_l  = lamp_l_q | {LAMPS{brake_l}};
      show_r  = lamp_r_q | {LAMPS{brake_r}};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) brake_q <= 1'b0;
      else      brake_q <= brake_d;
   end
`else
   assign show_l = lamp_l_q;
   assign show_r = lamp_r_q;
`endif

   assign led_l = ACTIVE_LOW ? ~show_l : show_l;
   assign led_r = ACTIVE_LOW ? ~show_r : show_r;
   assign busy  = busy_q;

endmodule

// File: tb/tb_tail_light_seq.sv
// tb/tb_tail_light_seq.sv - randomized and directed bench for tail_light_seq against a side/count model
module tb_tail_light_seq;

   localparam int LAMPS      = 3;
   localparam int TICK_DIV   = 4;
   localparam bit ACTIVE_LOW = 1'b1;
   localparam int VW         = 2 * LAMPS + 2;

   logic             clk, rst, left, right, halt;
`ifdef TAIL_BRAKE_EN
   logic             brake;
`endif
   logic [LAMPS-1:0] led_l, led_r;
   logic             busy, tick;
   logic [VW-1:0]    dut_vec;

   int checks = 0;
   int errors = 0;

   // Model: which side is sequencing (0 none, 1 left, 2 right), lamps lit, hazard phase (0 none, 1 on, 2 off).
   int cyc;
   int m_side, m_n, m_haz;
   bit m_brake;

   tail_light_seq #(
      .LAMPS      (LAMPS),
      .TICK_DIV   (TICK_DIV),
      .ACTIVE_LOW (ACTIVE_LOW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .left  (left),
      .right (right),
      .halt  (halt),
`ifdef TAIL_BRAKE_EN
      .brake (brake),
`endif
      .led_l (led_l),
      .led_r (led_r),
      .busy  (busy),
      .tick  (tick)
   );

   assign dut_vec = {led_l, led_r, busy, tick};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      m_side  = 0;
      m_n     = 0;
      m_haz   = 0;
      m_brake = 1'b0;
      cyc     = 0;
   endfunction

   function automatic void model_tick();
      bit haz;
      haz = halt || (left && right);
      if (m_haz != 0) begin
         m_haz = haz ? 3 - m_haz : 0;
      end else if (m_side != 0) begin
         if (haz) begin
            m_side = 0;
            m_n    = 0;
            m_haz  = 1;
         end else if (m_n == LAMPS) begin
            m_side = 0;
            m_n    = 0;
         end else begin
            m_n = m_n + 1;
         end
      end else if (haz) begin
         m_haz = 1;
      end else if (left) begin
         m_side = 1;
         m_n    = 1;
      end else if (right) begin
         m_side = 2;
         m_n    = 1;
      end
   endfunction

   function automatic logic [LAMPS-1:0] exp_pin(input int side);
      logic [LAMPS-1:0] lit;
      if (m_haz == 1)          lit = '1;
      else if (m_side == side) lit = LAMPS'((1 << m_n) - 1);
      else                     lit = '0;
      if (m_brake && m_haz == 0 && m_side != side) lit = '1;
      return ACTIVE_LOW ? ~lit : lit;
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      return {exp_pin(1), exp_pin(2), (m_haz != 0) || (m_side != 0),
              (cyc % TICK_DIV) == TICK_DIV - 1};
   endfunction

   task automatic step(output bit ticked);
      ticked = ((cyc % TICK_DIV) == TICK_DIV - 1);
      @(posedge clk);
      if (ticked) model_tick();
`ifdef TAIL_BRAKE_EN
      m_brake = brake;
`endif
      cyc = cyc + 1;
      #1;
   endtask

   task automatic step_tick();
      bit t;
      t = 1'b0;
      while (!t) step(t);
   endtask

   task automatic drain();
      left  = 1'b0;
      right = 1'b0;
      halt  = 1'b0;
      repeat (LAMPS + 2) step_tick();
   endtask

   task automatic test_reset();
      bit t;
      left = 1'b0; right = 1'b0; halt = 1'b0;
`ifdef TAIL_BRAKE_EN
      brake = 1'b0;
`endif
      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (dut_vec !== {{2*LAMPS{1'b1}}, 2'b00})
         begin errors++; $display("FAIL reset_state got=%b exp=%b", dut_vec, {{2*LAMPS{1'b1}}, 2'b00}); end
      @(negedge clk) rst = 1'b1;
      model_reset();
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (tick !== ((k % TICK_DIV) == TICK_DIV - 1))
            begin errors++; $display("FAIL first_tick k=%0d got=%b exp=%b", k, tick, (k % TICK_DIV) == TICK_DIV - 1); end
         step(t);
      end
   endtask

   task automatic test_hold_left();
      logic [2:0] tab [4];
      bit t;
      tab = '{3'b110, 3'b100, 3'b000, 3'b111};
      left = 1'b1;
      for (int j = 0; j < 8; j++) begin
         t = 1'b0;
         while (!t) begin
            step(t);
            checks++;
            if (dut_vec !== exp_vec())
               begin errors++; $display("FAIL hold_left_model cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec()); end
         end
         checks++;
         if (led_l !== tab[j % 4] || led_r !== 3'b111 || busy !== (j % 4 != 3))
            begin errors++; $display("FAIL hold_left_step j=%0d got=%b/%b/%b exp=%b/111/%b", j, led_l, led_r, busy, tab[j % 4], j % 4 != 3); end
      end
      drain();
   endtask

   task automatic test_right_pulse();
      logic [6:0] want [5];
      want = '{{3'b111, 3'b110, 1'b1}, {3'b111, 3'b100, 1'b1}, {3'b111, 3'b000, 1'b1},
               {3'b111, 3'b111, 1'b0}, {3'b110, 3'b111, 1'b1}};
      for (int k = 0; k < 5; k++) begin
         if (k == 0) right = 1'b1;
         if (k == 1) begin right = 1'b0; left = 1'b1; end
         step_tick();
         checks++;
         if ({led_l, led_r, busy} !== want[k] || dut_vec !== exp_vec())
            begin errors++; $display("FAIL right_pulse k=%0d got=%b exp=%b", k, {led_l, led_r, busy}, want[k]); end
      end
      drain();
   endtask

   task automatic test_hazard_preempt();
      logic [6:0] want [6];
      want = '{{3'b110, 3'b111, 1'b1}, {3'b100, 3'b111, 1'b1}, {3'b000, 3'b000, 1'b1},
               {3'b111, 3'b111, 1'b1}, {3'b000, 3'b000, 1'b1}, {3'b111, 3'b111, 1'b0}};
      for (int k = 0; k < 6; k++) begin
         if (k == 0) left = 1'b1;
         if (k == 2) halt = 1'b1;
         if (k == 5) begin halt = 1'b0; left = 1'b0; end
         step_tick();
         checks++;
         if ({led_l, led_r, busy} !== want[k] || dut_vec !== exp_vec())
            begin errors++; $display("FAIL hazard_preempt k=%0d got=%b exp=%b", k, {led_l, led_r, busy}, want[k]); end
      end
      drain();
   endtask

   task automatic test_left_right_hazard();
      logic [6:0] want [4];
      want = '{{3'b000, 3'b000, 1'b1}, {3'b111, 3'b111, 1'b1},
               {3'b000, 3'b000, 1'b1}, {3'b111, 3'b111, 1'b0}};
      for (int k = 0; k < 4; k++) begin
         if (k == 0) begin left = 1'b1; right = 1'b1; end
         if (k == 3) begin left = 1'b0; right = 1'b0; end
         step_tick();
         checks++;
         if ({led_l, led_r, busy} !== want[k] || dut_vec !== exp_vec())
            begin errors++; $display("FAIL lr_hazard k=%0d got=%b exp=%b", k, {led_l, led_r, busy}, want[k]); end
      end
      drain();
   endtask

   task automatic test_async_reset();
      bit t;
      left = 1'b1;
      step_tick();
      step_tick();
      step(t);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (dut_vec !== {{2*LAMPS{1'b1}}, 2'b00})
         begin errors++; $display("FAIL async_reset got=%b exp=%b", dut_vec, {{2*LAMPS{1'b1}}, 2'b00}); end
      left = 1'b0;
      @(negedge clk) rst = 1'b1;
      model_reset();
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (dut_vec !== exp_vec())
            begin errors++; $display("FAIL after_reset k=%0d got=%b exp=%b", k, dut_vec, exp_vec()); end
         step(t);
      end
   endtask

   task automatic test_random();
      bit t;
      for (int k = 0; k < 800; k++) begin
         left  = ($urandom_range(0, 2) == 0);
         right = ($urandom_range(0, 2) == 0);
         halt  = ($urandom_range(0, 9) == 0);
`ifdef TAIL_BRAKE_EN
         brake = ($urandom_range(0, 3) == 0);
`endif
         step(t);
         checks++;
         if (dut_vec !== exp_vec())
            begin errors++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec()); end
      end
`ifdef TAIL_BRAKE_EN
      brake = 1'b0;
`endif
      drain();
   endtask

`ifdef TAIL_BRAKE_EN
   task automatic test_brake();
      bit t;
      brake = 1'b1;
      step(t);
      checks++;
      if ({led_l, led_r} !== 6'b000000)
         begin errors++; $display("FAIL brake_idle got=%b exp=000000", {led_l, led_r}); end
      left = 1'b1;
      for (int k = 0; k < 4 * TICK_DIV; k++) begin
         step(t);
         checks++;
         if (led_r !== 3'b000 || dut_vec !== exp_vec())
            begin errors++; $display("FAIL brake_left cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec()); end
      end
      brake = 1'b0;
      drain();
   endtask
`endif

   initial begin
      test_reset();
      test_hold_left();
      test_right_pulse();
      test_hazard_preempt();
      test_left_right_hazard();
      test_async_reset();
`ifdef TAIL_BRAKE_EN
      test_brake();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tail_light_seq.md
Name: tail_light_seq

Overview:
Parametrised tail-light / turn-signal sequencer driving LAMPS lamps per side. It replaces a derived divided clock with a single-clock design that uses a prescaler tick enable. It adds a flashing hazard mode, a busy flag and polarity selection. It sits between the switch/debounce logic and the board LED pins.

Parameters:
LAMPS, 3, lamps per side; legal range 2..8.
TICK_DIV, 12500000, clk cycles per sequencing step; must be ≥ 2. The prescaler width is a localparam equal to $clog2(TICK_DIV).
ACTIVE_LOW, 1, 1 means the led_l and led_r pins are inverted (lamp lit = 0).

Ports:
clk  in  1  system clock; all flops sample on its rising edge.
rst  in  1  reset, asynchronous, active-low.
left  in  1  left-turn request, synchronous to clk.
right  in  1  right-turn request, synchronous to clk.
halt  in  1  hazard request, synchronous to clk.
brake  in  1  brake request; present only with TAIL_BRAKE_EN.
led_l  out  LAMPS  left lamps; bit 0 is the innermost lamp.
led_r  out  LAMPS  right lamps; bit 0 is the innermost lamp.
busy  out  1  high whenever state ≠ IDLE.
tick  out  1  one-cycle step pulse, brought out for debug.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE, idx = 0, prescaler = 0, tick = 0, busy = 0.
  - Logical lamps are all off, so the pins are all 1 when ACTIVE_LOW=1 and all 0 otherwise.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - tick = 1 exactly in the cycle the count equals TICK_DIV-1, giving a period of TICK_DIV cycles.
- Step timing:
  - The FSM and idx update only in a tick cycle; requests between ticks are not latched.
  - Lamp outputs are registered and change in the cycle after the tick.
- Hazard condition: haz = halt | (left & right).
- States and transitions (all evaluated on tick):
  - IDLE: haz → HAZ_ON. Otherwise left → LEFT with idx=1; right → RIGHT with idx=1; otherwise stay.
  - LEFT / RIGHT:
    - haz → HAZ_ON, idx=0. Hazard preempts mid-sequence.
    - Otherwise, if idx==LAMPS → IDLE, idx=0. This produces a one-step all-off gap; a held request restarts on the next tick.
    - Otherwise idx+1.
    - Releasing the request mid-sequence does not abort; the sequence completes.
    - The opposite-side request is ignored until IDLE.
  - HAZ_ON: haz → HAZ_OFF, else IDLE.
  - HAZ_OFF: haz → HAZ_ON, else IDLE.
- Lamp patterns (logical, 1 = lit):
  - LEFT: led_l[i] = (i < idx); led_r = 0.
  - RIGHT is the mirror of LEFT.
  - HAZ_ON: both sides all 1s.
  - HAZ_OFF and IDLE: both sides all 0s.
- Output polarity: pins = ACTIVE_LOW ? ~logical : logical.
- Widths:
  - idx is $clog2(LAMPS+1) bits.
  - The comparison idx==LAMPS is exact; idx never exceeds LAMPS.
- Reset asserted mid-operation forces the reset values immediately. After release the prescaler restarts from 0, so the first tick arrives TICK_DIV cycles later.

Optional Feature:
- Macro TAIL_BRAKE_EN.
- Defined:
  - The brake port exists.
  - While brake=1, any side not displaying a turn sequence shows all lamps lit steady. This covers IDLE (both sides) and the non-active side in LEFT/RIGHT.
  - Hazard states ignore brake.
  - brake is applied combinationally from its registered sample, updated every cycle rather than only on tick.
- Not defined: no brake port and no brake logic.

Decomposition:
- Shared package tail_light_pkg holds:
  - the state encoding constants IDLE, LEFT, RIGHT, HAZ_ON, HAZ_OFF (3-bit);
  - LAMPS_MIN = 2 and LAMPS_MAX = 8 for elaboration checks.
- One sub-module, tick_gen, contains the prescaler and tick output and is parameterised by TICK_DIV.

Test Plan:
Use LAMPS=3, TICK_DIV=4, ACTIVE_LOW=1 unless stated.
- rst=0 → led_l=led_r=3'b111 (pins), busy=0. Release rst → first tick 4 cycles later.
- Hold left → led_l pins 110, 100, 000, 111 on successive ticks, then repeat; led_r stays 111; busy drops during the gap step.
- Pulse right for one tick only → the full 3-step sequence completes, then IDLE; a left request raised mid-sequence is ignored.
- In LEFT at idx=2, assert halt → next tick gives both sides 000 (pins). Holding halt alternates 000/111 every tick; releasing it → IDLE within 1 tick.
- Assert left&right simultaneously from IDLE → hazard flashing, identical to halt.
- Assert rst=0 mid-sequence, asynchronously between clock edges → outputs reach reset values without a clk edge.
- TAIL_BRAKE_EN: brake=1 in IDLE → both sides 000. With brake=1 and left held → led_r 000 steady while led_l sequences.
